// File: rtl/conv_operand_loader_if.sv
// Operand-loader bus: byte stream in, kernel/window SRAM write ports and convolver handshake out.
interface conv_operand_loader_if #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned SRAM_ADDR_WIDTH = 4
);
   logic                       load;
   logic                       reuse_kernel;
   logic                       valid;
   logic [DATA_WIDTH-1:0]      data;
   logic                       ready;
   logic                       kernel_we;
   logic [5:0]                 kernel_addr;
   logic [DATA_WIDTH-1:0]      kernel_data;
   logic                       window_we;
   logic [SRAM_ADDR_WIDTH-1:0] window_addr;
   logic [DATA_WIDTH-1:0]      window1_data;
   logic [DATA_WIDTH-1:0]      window2_data;
   logic                       start;
   logic                       done;
   logic                       busy;

   // The loader itself.
   modport slave (
      input  load, reuse_kernel, valid, data, done,
      output ready, kernel_we, kernel_addr, kernel_data,
             window_we, window_addr, window1_data, window2_data,
             start, busy
   );

   // Stream source / convolver side.
   modport master (
      output load, reuse_kernel, valid, data, done,
      input  ready, kernel_we, kernel_addr, kernel_data,
             window_we, window_addr, window1_data, window2_data,
             start, busy
   );
endinterface

// File: rtl/conv_operand_loader.sv
// Writes K*K kernel bytes, then K*K paired window bytes, into the convolver's operand SRAMs,
// then pulses start and waits for done; a held kernel may be reused to skip the kernel phase.
module conv_operand_loader #(
   parameter int unsigned KERNEL_SIZE     = 3,
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned SRAM_ADDR_WIDTH = 4
) (
   input logic                  i_clk,
   input logic                  i_rst,
   conv_operand_loader_if.slave bus
);
   localparam int unsigned N = KERNEL_SIZE * KERNEL_SIZE;
   localparam logic [5:0]                 K_LAST = 6'(N - 1);
   localparam logic [SRAM_ADDR_WIDTH-1:0] P_LAST = SRAM_ADDR_WIDTH'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_KERNEL,
      LOAD_WIN,
      START,
      WAIT_DONE
   } state_t;

   state_t                     state;
   logic [5:0]                 kcnt;
   logic [SRAM_ADDR_WIDTH-1:0] pcnt;
   logic                       phase;
   logic                       kernel_held;
   logic [DATA_WIDTH-1:0]      hold;

   logic                       ready;
   logic                       accept;

   logic                       kernel_we;
   logic [5:0]                 kernel_addr;
   logic [DATA_WIDTH-1:0]      kernel_data;
   logic                       window_we;
   logic [SRAM_ADDR_WIDTH-1:0] window_addr;
   logic [DATA_WIDTH-1:0]      window1_data;
   logic [DATA_WIDTH-1:0]      window2_data;
   logic                       start;

   always_comb begin
      ready  = (state == LOAD_KERNEL) || (state == LOAD_WIN);
      accept = bus.valid && ready;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         kcnt         <= '0;
         pcnt         <= '0;
         phase        <= 1'b0;
         kernel_held  <= 1'b0;
         hold         <= '0;
         kernel_we    <= 1'b0;
         kernel_addr  <= '0;
         kernel_data  <= '0;
         window_we    <= 1'b0;
         window_addr  <= '0;
         window1_data <= '0;
         window2_data <= '0;
         start        <= 1'b0;
      end else begin
         kernel_we <= 1'b0;
         window_we <= 1'b0;
         start     <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.load) begin
                  kcnt  <= '0;
                  pcnt  <= '0;
                  phase <= 1'b0;
                  state <= (bus.reuse_kernel && kernel_held) ? LOAD_WIN : LOAD_KERNEL;
               end
            end
            LOAD_KERNEL: begin
               if (accept) begin
                  kernel_we   <= 1'b1;
                  kernel_addr <= kcnt;
                  kernel_data <= bus.data;
                  if (kcnt == K_LAST) begin
                     kernel_held <= 1'b1;
                     state       <= LOAD_WIN;
                  end else begin
                     kcnt <= kcnt + 6'd1;
                  end
               end
            end
            LOAD_WIN: begin
               // Even beats are parked in hold so both window SRAMs get one shared write per pair.
               if (accept) begin
                  if (!phase) begin
                     hold  <= bus.data;
                     phase <= 1'b1;
                  end else begin
                     window_we    <= 1'b1;
                     window_addr  <= pcnt;
                     window1_data <= hold;
                     window2_data <= bus.data;
                     phase        <= 1'b0;
                     if (pcnt == P_LAST) begin
                        state <= START;
                     end else begin
                        pcnt <= pcnt + SRAM_ADDR_WIDTH'(1);
                     end
                  end
               end
            end
            START: begin
               start <= 1'b1;
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (bus.done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ready        = ready;
   assign bus.busy         = (state != IDLE);
   assign bus.kernel_we    = kernel_we;
   assign bus.kernel_addr  = kernel_addr;
   assign bus.kernel_data  = kernel_data;
   assign bus.window_we    = window_we;
   assign bus.window_addr  = window_addr;
   assign bus.window1_data = window1_data;
   assign bus.window2_data = window2_data;
   assign bus.start        = start;
endmodule

// File: tb/tb_conv_operand_loader.sv
// Directed bench for conv_operand_loader: kernel/window write sequences, reuse, gaps, reset and ignored controls.
module tb_conv_operand_loader;
   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   kw;
   int   ww;

   conv_operand_loader_if #(.DATA_WIDTH(8), .SRAM_ADDR_WIDTH(4)) bus ();

   conv_operand_loader #(
      .KERNEL_SIZE(3),
      .DATA_WIDTH(8),
      .SRAM_ADDR_WIDTH(4)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe counters catch writes the directed checks might not be looking at.
   always @(negedge clk) begin
      if (bus.kernel_we === 1'b1) kw++;
      if (bus.window_we === 1'b1) ww++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [7:0] b);
      chk("ready_before_beat", 32'(bus.ready), 32'd1);
      bus.valid = 1'b1;
      bus.data  = b;
      tick;
      bus.valid = 1'b0;
      bus.data  = 8'hEE;
   endtask

   task automatic gap;
      tick;
      chk("gap_kernel_we", 32'(bus.kernel_we), 32'd0);
      chk("gap_window_we", 32'(bus.window_we), 32'd0);
   endtask

   task automatic kernel_phase(input int base, input bit gaps);
      for (int j = 0; j < 9; j++) begin
         beat(8'(base + j));
         chk("kernel_we", 32'(bus.kernel_we), 32'd1);
         chk("kernel_addr", 32'(bus.kernel_addr), 32'(j));
         chk("kernel_data", 32'(bus.kernel_data), 32'(base + j));
         chk("kernel_phase_window_we", 32'(bus.window_we), 32'd0);
         if (gaps) gap;
      end
   endtask

   task automatic window_phase(input int base, input bit gaps);
      for (int p = 0; p < 9; p++) begin
         beat(8'(base + 2 * p));
         chk("win_even_no_write", 32'(bus.window_we), 32'd0);
         chk("win_even_kernel_we", 32'(bus.kernel_we), 32'd0);
         if (gaps) gap;
         beat(8'(base + 2 * p + 1));
         chk("window_we", 32'(bus.window_we), 32'd1);
         chk("window_addr", 32'(bus.window_addr), 32'(p));
         chk("window1_data", 32'(bus.window1_data), 32'(base + 2 * p));
         chk("window2_data", 32'(bus.window2_data), 32'(base + 2 * p + 1));
         chk("start_early", 32'(bus.start), 32'd0);
         if (gaps && p < 8) gap;
      end
      chk("ready_after_window", 32'(bus.ready), 32'd0);
      tick;
      chk("start_pulse", 32'(bus.start), 32'd1);
      chk("start_no_we", 32'(bus.window_we), 32'd0);
      tick;
      chk("start_one_cycle", 32'(bus.start), 32'd0);
      chk("busy_wait_done", 32'(bus.busy), 32'd1);
      chk("ready_wait_done", 32'(bus.ready), 32'd0);
   endtask

   task automatic finish_done;
      bus.done = 1'b1;
      tick;
      bus.done = 1'b0;
      chk("busy_after_done", 32'(bus.busy), 32'd0);
      chk("ready_idle", 32'(bus.ready), 32'd0);
   endtask

   task automatic do_load(input bit reuse);
      bus.load         = 1'b1;
      bus.reuse_kernel = reuse;
      tick;
      bus.load         = 1'b0;
      bus.reuse_kernel = 1'b0;
      chk("busy_after_load", 32'(bus.busy), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_kernel_we"}, 32'(bus.kernel_we), 32'd0);
      chk({tag, "_kernel_addr"}, 32'(bus.kernel_addr), 32'd0);
      chk({tag, "_kernel_data"}, 32'(bus.kernel_data), 32'd0);
      chk({tag, "_window_we"}, 32'(bus.window_we), 32'd0);
      chk({tag, "_window_addr"}, 32'(bus.window_addr), 32'd0);
      chk({tag, "_window1_data"}, 32'(bus.window1_data), 32'd0);
      chk({tag, "_window2_data"}, 32'(bus.window2_data), 32'd0);
      chk({tag, "_start"}, 32'(bus.start), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_ready"}, 32'(bus.ready), 32'd0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      kw    = 0;
      ww    = 0;
      rst              = 1'b1;
      bus.load         = 1'b0;
      bus.reuse_kernel = 1'b0;
      bus.valid        = 1'b0;
      bus.data         = 8'h00;
      bus.done         = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      check_all_zero("reset");

      // Beats while idle are ignored.
      bus.valid = 1'b1;
      bus.data  = 8'h55;
      tick;
      bus.valid = 1'b0;
      chk("idle_beat_kernel_we", 32'(bus.kernel_we), 32'd0);
      chk("idle_beat_busy", 32'(bus.busy), 32'd0);

      // 1: continuous stream, kernel 1..9 then window 10..27.
      kw = 0; ww = 0;
      do_load(1'b0);
      kernel_phase(1, 1'b0);
      window_phase(10, 1'b0);
      finish_done;
      chk("t1_kernel_writes", 32'(kw), 32'd9);
      chk("t1_window_writes", 32'(ww), 32'd9);

      // 3: kernel reuse skips the kernel phase.
      kw = 0; ww = 0;
      do_load(1'b1);
      window_phase(30, 1'b0);
      finish_done;
      chk("t3_kernel_writes", 32'(kw), 32'd0);
      chk("t3_window_writes", 32'(ww), 32'd9);

      // 2: valid toggling every other cycle gives the same write sequence.
      kw = 0; ww = 0;
      do_load(1'b0);
      kernel_phase(1, 1'b1);
      window_phase(10, 1'b1);
      finish_done;
      chk("t2_kernel_writes", 32'(kw), 32'd9);
      chk("t2_window_writes", 32'(ww), 32'd9);

      // 4 + 6: reuse after reset still loads the kernel; stray done/load are ignored.
      rst = 1'b1;
      tick;
      rst = 1'b0;
      kw = 0; ww = 0;
      do_load(1'b1);
      kernel_phase(100, 1'b0);
      bus.done = 1'b1;
      tick;
      bus.done = 1'b0;
      chk("t6_done_in_win_busy", 32'(bus.busy), 32'd1);
      chk("t6_done_in_win_ready", 32'(bus.ready), 32'd1);
      window_phase(150, 1'b0);
      bus.load = 1'b1;
      tick;
      bus.load = 1'b0;
      chk("t6_load_in_wait_busy", 32'(bus.busy), 32'd1);
      tick;
      chk("t6_still_waiting", 32'(bus.busy), 32'd1);
      chk("t6_no_kernel_we", 32'(bus.kernel_we), 32'd0);
      finish_done;
      chk("t4_kernel_writes", 32'(kw), 32'd9);
      chk("t4_window_writes", 32'(ww), 32'd9);

      // 5: reset after 5 window bytes clears everything and forgets the kernel.
      do_load(1'b1);
      for (int i = 0; i < 5; i++) begin
         beat(8'(200 + i));
      end
      chk("t5_window_addr_before_rst", 32'(bus.window_addr), 32'd1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check_all_zero("t5_rst");
      kw = 0; ww = 0;
      do_load(1'b1);
      kernel_phase(50, 1'b0);
      window_phase(70, 1'b0);
      finish_done;
      chk("t5_kernel_writes", 32'(kw), 32'd9);
      chk("t5_window_writes", 32'(ww), 32'd9);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
